btn_debounce_pulse: RTL and testbench
=====================================

// Module: btn_debounce_pulse
// PURPOSE
//   Front-end conditioner for the lab flip-flop stages. It takes a raw pushbutton (btnC) and
//   the raw J/K slide switches, synchronises and debounces them, and emits one clean 1-cycle
//   strobe per accepted press. J/K are sampled and held at the moment of acceptance.
//   Output feeds the downstream JK storage stage as its clock-enable/edge strobe plus stable J/K.
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000  stable-input cycles required to accept a level change (10 ms @ 100 MHz); must be >= 2
//   SYNC_STAGES      2          flip-flops in each input synchroniser chain; must be >= 2
//   CNT_W            $clog2(DEBOUNCE_CYCLES)  debounce counter width (derived localparam, not overridable)
// PORTS
//   clk        in   1  system clock, all logic on posedge
//   rst_n      in   1  synchronous reset, active-low
//   btn_raw    in   1  asynchronous, bouncing pushbutton
//   j_raw      in   1  asynchronous J switch
//   k_raw      in   1  asynchronous K switch
//   btn_level  out  1  debounced button level
//   btn_rise   out  1  1-cycle pulse on accepted press (0->1)
//   btn_fall   out  1  1-cycle pulse on accepted release (1->0)
//   j_held     out  1  synchronised J captured on the cycle btn_rise asserts
//   k_held     out  1  synchronised K captured on the cycle btn_rise asserts
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): all sync flops 0, counter 0, state LOW_STABLE, every output 0.
//   - Sync: btn/j/k each pass SYNC_STAGES flops; btn_s, j_s, k_s are the last-stage values.
//   - FSM states: LOW_STABLE, RISE_WAIT, HIGH_STABLE, FALL_WAIT.
//     LOW_STABLE:  btn_s=1 -> RISE_WAIT, cnt<=0.
//     RISE_WAIT:   btn_s=0 -> LOW_STABLE (bounce rejected, no pulse);
//                  else if cnt==DEBOUNCE_CYCLES-1 -> HIGH_STABLE, btn_level<=1, btn_rise<=1,
//                  j_held<=j_s, k_held<=k_s; else cnt<=cnt+1.
//     HIGH_STABLE: btn_s=0 -> FALL_WAIT, cnt<=0.
//     FALL_WAIT:   btn_s=1 -> HIGH_STABLE (no pulse);
//                  else if cnt==DEBOUNCE_CYCLES-1 -> LOW_STABLE, btn_level<=0, btn_fall<=1;
//                  else cnt<=cnt+1.
//   - btn_rise/btn_fall are registered, high exactly one cycle, never both in the same cycle.
//   - Latency: raw edge held clean -> pulse visible SYNC_STAGES + DEBOUNCE_CYCLES + 1 posedges later.
//   - j_held/k_held change only on a btn_rise cycle; J/K toggling at other times is ignored.
//   - Counter never wraps: it is cleared on entry to a WAIT state and stops at DEBOUNCE_CYCLES-1.
//   - Button held through reset: after release of rst_n, the press is debounced and one btn_rise issues.
//   - Reset mid-debounce: the wait is abandoned, no pulse issues, outputs return to 0 on that edge.
//   - Any glitch shorter than DEBOUNCE_CYCLES stable cycles produces no pulse and no level change.
// STRUCTURE
//   - Shared package debounce_pkg: state encoding localparams (LOW_STABLE=2'd0, RISE_WAIT=2'd1,
//     HIGH_STABLE=2'd2, FALL_WAIT=2'd3) and the default DEBOUNCE_CYCLES / SYNC_STAGES constants.
//   - One sub-module sync_chain (param STAGES, 1-bit in/out, reset to 0), instantiated 3x.
//   - FSM, counter and capture registers stay in this module.
// TESTING (bench overrides DEBOUNCE_CYCLES=8, SYNC_STAGES=2)
//   - Reset: hold rst_n=0 3 cycles with btn_raw=0 -> all outputs 0; no pulses for 20 cycles.
//   - Clean press: btn_raw 0->1 held 20 cycles -> btn_rise high exactly 1 cycle, 11 posedges after edge;
//     btn_level=1 thereafter.
//   - Bounce: btn_raw toggles every 3 cycles x6, then holds 1 -> single btn_rise, none during bounce.
//   - J/K capture: j_raw=1,k_raw=0 before press, flip to 0/1 mid-hold -> j_held=1,k_held=0 unchanged
//     until next btn_rise.
//   - Release: after accepted press drop btn_raw for 20 cycles -> one btn_fall, btn_level=0, no btn_rise.
//   - Reset mid-wait: assert rst_n=0 at cnt=4 in RISE_WAIT -> no pulse, outputs 0;
//     btn still high after reset -> one btn_rise 11 cycles later.

Source files
------------

// File: rtl/btn_debounce_pulse_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg : state encoding and default timing constants for btn_debounce_pulse
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package debounce_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_SYNC_STAGES     = 2;

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'd0,
        RISE_WAIT   = 2'd1,
        HIGH_STABLE = 2'd2,
        FALL_WAIT   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/btn_debounce_pulse_if.sv
// ---------------------------------------------------------------------------
// btn_debounce_pulse_if : raw button/switch inputs and conditioned strobe outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface btn_debounce_pulse_if;
    logic btn_raw;
    logic j_raw;
    logic k_raw;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;
    logic j_held;
    logic k_held;

    modport master (
        output btn_raw, j_raw, k_raw,
        input  btn_level, btn_rise, btn_fall, j_held, k_held
    );

    modport slave (
        input  btn_raw, j_raw, k_raw,
        output btn_level, btn_rise, btn_fall, j_held, k_held
    );
endinterface

`default_nettype wire

// File: rtl/btn_debounce_pulse_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain : STAGES-deep single-bit synchroniser, synchronous active-low reset to 0
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_chain #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic d,
    output logic      q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// btn_debounce_pulse : synchronise + debounce a pushbutton, emit 1-cycle press/release
//                      strobes and capture J/K on each accepted press
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_debounce_pulse
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input wire logic            clk,
    input wire logic            rst_n,
    btn_debounce_pulse_if.slave bus
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic btn_s;
    logic j_s;
    logic k_s;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.btn_raw),
        .q     (btn_s)
    );

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync_j (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.j_raw),
        .q     (j_s)
    );

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync_k (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.k_raw),
        .q     (k_s)
    );

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic             j_held_q;
    logic             k_held_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= LOW_STABLE;
            cnt      <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            j_held_q <= 1'b0;
            k_held_q <= 1'b0;
        end else begin
            // Strobes default low so each accepted edge yields exactly one cycle.
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state)
                LOW_STABLE: begin
                    if (btn_s) begin
                        state <= RISE_WAIT;
                        cnt   <= '0;
                    end
                end
                RISE_WAIT: begin
                    if (!btn_s) begin
                        state <= LOW_STABLE;
                    end else if (cnt == CNT_LAST) begin
                        state    <= HIGH_STABLE;
                        level_q  <= 1'b1;
                        rise_q   <= 1'b1;
                        j_held_q <= j_s;
                        k_held_q <= k_s;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH_STABLE: begin
                    if (!btn_s) begin
                        state <= FALL_WAIT;
                        cnt   <= '0;
                    end
                end
                FALL_WAIT: begin
                    if (btn_s) begin
                        state <= HIGH_STABLE;
                    end else if (cnt == CNT_LAST) begin
                        state   <= LOW_STABLE;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= LOW_STABLE;
                end
            endcase
        end
    end

    assign bus.btn_level = level_q;
    assign bus.btn_rise  = rise_q;
    assign bus.btn_fall  = fall_q;
    assign bus.j_held    = j_held_q;
    assign bus.k_held    = k_held_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce_pulse : directed self-checking bench, DEBOUNCE_CYCLES=8, SYNC_STAGES=2
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_btn_debounce_pulse;

    localparam int DEB  = 8;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + DEB + 1;

    logic clk = 1'b0;
    logic rst_n;

    btn_debounce_pulse_if bus ();

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES (DEB),
        .SYNC_STAGES     (SYNC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc;
    int rise_cnt;
    int fall_cnt;
    int last_rise_cyc;
    int last_fall_cyc;
    int both_cnt = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        cyc           = 0;
        rise_cnt      = 0;
        fall_cnt      = 0;
        last_rise_cyc = -1;
        last_fall_cyc = -1;
    endtask

    // Advance n posedges, sampling 1 time unit after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.btn_rise === 1'b1) begin
                rise_cnt++;
                last_rise_cyc = cyc;
            end
            if (bus.btn_fall === 1'b1) begin
                fall_cnt++;
                last_fall_cyc = cyc;
            end
            if (bus.btn_rise === 1'b1 && bus.btn_fall === 1'b1) both_cnt++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"}, int'(bus.btn_level), 0);
        check({tag, "_rise"},  int'(bus.btn_rise),  0);
        check({tag, "_fall"},  int'(bus.btn_fall),  0);
        check({tag, "_j"},     int'(bus.j_held),    0);
        check({tag, "_k"},     int'(bus.k_held),    0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.btn_raw = 1'b0;
        bus.j_raw   = 1'b0;
        bus.k_raw   = 1'b0;
        clear_mon();

        // Reset, then idle
        step(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        clear_mon();
        step(20);
        check("idle_rise_cnt", rise_cnt, 0);
        check("idle_fall_cnt", fall_cnt, 0);

        // Clean press with J=1/K=0 set up beforehand
        bus.j_raw = 1'b1;
        bus.k_raw = 1'b0;
        step(3);
        clear_mon();
        bus.btn_raw = 1'b1;
        step(LAT);
        check("press_rise_cyc", last_rise_cyc, LAT);
        check("press_rise_cnt", rise_cnt, 1);
        check("press_level", int'(bus.btn_level), 1);
        check("press_j", int'(bus.j_held), 1);
        check("press_k", int'(bus.k_held), 0);

        // J/K flip mid-hold must not disturb captured values
        bus.j_raw = 1'b0;
        bus.k_raw = 1'b1;
        step(20 - LAT);
        check("hold_rise_cnt", rise_cnt, 1);
        check("hold_rise_pulse", int'(bus.btn_rise), 0);
        check("hold_level", int'(bus.btn_level), 1);
        check("hold_j", int'(bus.j_held), 1);
        check("hold_k", int'(bus.k_held), 0);

        // Release
        clear_mon();
        bus.btn_raw = 1'b0;
        step(20);
        check("rel_fall_cnt", fall_cnt, 1);
        check("rel_fall_cyc", last_fall_cyc, LAT);
        check("rel_rise_cnt", rise_cnt, 0);
        check("rel_level", int'(bus.btn_level), 0);
        check("rel_j", int'(bus.j_held), 1);

        // Bounce: 6 toggles of 3 cycles each, then hold high
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            bus.btn_raw = (i % 2 == 0);
            step(3);
        end
        check("bounce_rise_cnt", rise_cnt, 0);
        check("bounce_fall_cnt", fall_cnt, 0);
        check("bounce_level", int'(bus.btn_level), 0);
        clear_mon();
        bus.btn_raw = 1'b1;
        step(20);
        check("settle_rise_cnt", rise_cnt, 1);
        check("settle_rise_cyc", last_rise_cyc, LAT);
        check("settle_fall_cnt", fall_cnt, 0);
        check("settle_level", int'(bus.btn_level), 1);
        check("settle_j", int'(bus.j_held), 0);
        check("settle_k", int'(bus.k_held), 1);

        // Release, then reset in the middle of a rise wait
        bus.btn_raw = 1'b0;
        step(20);
        check("rel2_level", int'(bus.btn_level), 0);
        bus.j_raw = 1'b1;
        bus.k_raw = 1'b0;
        clear_mon();
        bus.btn_raw = 1'b1;
        step(SYNC + 1 + 4);
        check("midwait_rise_cnt", rise_cnt, 0);
        rst_n = 1'b0;
        step(1);
        check_all_zero("midrst");
        check("midrst_rise_cnt", rise_cnt, 0);
        rst_n = 1'b1;
        clear_mon();
        step(20);
        check("postrst_rise_cnt", rise_cnt, 1);
        check("postrst_rise_cyc", last_rise_cyc, LAT);
        check("postrst_level", int'(bus.btn_level), 1);
        check("postrst_j", int'(bus.j_held), 1);
        check("postrst_k", int'(bus.k_held), 0);

        check("never_both", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
